oam_dma_controller: RTL and testbench
=====================================

# oam_dma_controller

Sprite DMA sequencer and CPU-bus arbiter. Sits between the CPU core and the CPU-side memory wrapper. Detects a CPU write to $4014, halts the CPU via `rdy`, then takes the memory bus and copies 256 bytes from page `$XX00–$XXFF` to the PPU OAM data port ($2004). When idle, the CPU bus passes through unchanged.

## Interface
Parameters:
- `READ_LAT`, 1: `clk` cycles from bus read strobe to valid `bus_rdata`; synchronous ROM/RAM.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `cpu_ce`  in  1  CPU cycle enable; one pulse per CPU cycle; pulses at least `READ_LAT+1` clks apart.
- `cpu_cs`  in  1  CPU bus select, active low.
- `cpu_rd` / `cpu_wr`  in  1 each  CPU strobes.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `rdy`  out  1  CPU ready; 0 halts the CPU.
- `bus_cs`  out  1  memory-side select, active low.
- `bus_rd` / `bus_wr`  out  1 each  memory-side strobes.
- `bus_addr`  out  16  memory-side address.
- `bus_wdata`  out  8  memory-side write data; the top level drives the tristate.
- `bus_rdata`  in  8  memory-side read data.
- `dma_active`  out  1  1 while the DMA owns the bus.

## Operation
- Trigger: on `cpu_ce` with `!cpu_cs & cpu_wr & cpu_addr==16'h4014`, latch `page <= cpu_wdata` and go IDLE→HALT.
- States:
  - IDLE: pass-through, `bus_* = cpu_*`, `rdy=1`, `dma_active=0`.
  - HALT: one CPU cycle, bus idle (`bus_cs=1`). The CPU completes its write.
  - ALIGN: one dummy cycle, entered only if the cycle after HALT is a put cycle.
  - READ: `bus_addr={page,idx}`, `bus_rd=1`, `bus_cs=0`. On ending `cpu_ce`, `data_q <= bus_rdata` and go to WRITE.
  - WRITE: `bus_addr=16'h2004`, `bus_wr=1`, `bus_wdata=data_q`, `bus_cs=0`. On ending `cpu_ce`, `idx <= idx+1`. If `idx==8'hFF`, go to IDLE; otherwise go to READ.
- Parity: a 1-bit `put` toggles on every `cpu_ce` and resets to 0 (get). READ always occupies get cycles and WRITE always occupies put cycles.
- Total stall: 513 CPU cycles (HALT + 512) or 514 with ALIGN.
- `idx` is 8 bits. It resets to 0 on trigger and is never wrapped mid-transfer; the transfer ends after exactly 256 writes.
- During any non-IDLE state: `rdy=0`, `dma_active=1`, and CPU bus inputs are ignored.
- Re-trigger while non-IDLE is ignored; the CPU is halted anyway.
- All state changes occur only on `clk` edges with `cpu_ce=1`. With `cpu_ce=0`, all registers hold.
- Reset (any state, including mid-transfer) takes effect on the next `clk` edge:
  - state=IDLE, `idx=0`, `page=0`, `data_q=0`, `put=0`.
  - `rdy=1`, `dma_active=0`.
  - `bus_*` follows CPU pass-through.
  - The partial transfer is abandoned and no further writes are issued.

## Timing
- `rdy`, `dma_active`, `bus_addr`, `bus_rd`, `bus_wr`, `bus_wdata` and `bus_cs` (non-IDLE) are registered and change one `clk` after the qualifying `cpu_ce`.
- `rdy` falls one `clk` after the trigger `cpu_ce`. It rises one `clk` after the `cpu_ce` that ends the final WRITE.
- IDLE pass-through is combinational from `cpu_*` to `bus_*`.
- Read-data sampling requires `bus_rdata` valid `READ_LAT` clks after strobe. The `cpu_ce` spacing rule guarantees this.

## Configuration
- `OAM_DMA_ALIGN_EN` defined: ALIGN state compiled in; stall is 513 or 514 cycles per parity, cycle-accurate.
- Undefined: HALT goes directly to READ and `put` is not consulted; stall is always 513 cycles. READ/WRITE may then fall on either parity.

## Structure
- Shared package `NesBus`:
  - `OAM_DMA_REG = 16'h4014`
  - `OAM_DATA_REG = 16'h2004`
  - `dma_state_t` enum {IDLE, HALT, ALIGN, READ, WRITE}
- Single module, no sub-modules. Counter, FSM and output mux are all local.

## Test plan
- Write $02 to $4014 on a get cycle, RAM $0200–$02FF = `i^8'h5A`:
  - `rdy` low for 513 `cpu_ce`.
  - 256 writes to $2004 with data `0^5A … FF^5A` in order.
- Same stimulus triggered on a put cycle with `OAM_DMA_ALIGN_EN`: 514-cycle stall. Without the macro: 513.
- Page $80 (ROM): reads $8000–$80FF. No `bus_wr` to any address except $2004 while `dma_active`.
- Assert `rst_n=0` after 100 writes:
  - `rdy=1` and `dma_active=0` next `clk`.
  - Write count stays 100.
  - A subsequent $4014 write restarts with `idx=0`.
- Insert random `cpu_ce` gaps of 2–7 clks: write count, data order and stall in CPU cycles are unchanged. Registers hold across gaps.
- CPU write to $4015 or $2004 while IDLE: no trigger, pass-through only, `rdy` stays 1.

Source files
------------

// File: rtl/oam_dma_controller_pkg.sv
// Shared NES CPU-bus constants and the sprite DMA state encoding.
package NesBus;

    localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA_REG = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite DMA sequencer and CPU-bus arbiter: copies page $XX00-$XXFF to $2004.
// Define OAM_DMA_ALIGN_EN to add the get/put ALIGN cycle after HALT.
module oam_dma_controller
    import NesBus::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce,
    input  logic        cpu_cs,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        rdy,
    output logic        bus_cs,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active
);

    if (READ_LAT < 1) begin : g_lat_check
        $error("READ_LAT must be at least 1");
    end

    dma_state_t state;
    dma_state_t state_nxt;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_q;
    logic       trigger;

    assign trigger = cpu_ce && !cpu_cs && cpu_wr && (cpu_addr == OAM_DMA_REG);

`ifdef OAM_DMA_ALIGN_EN
    // Parity of the current CPU cycle: 0 = get, 1 = put.
    logic put;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            put <= 1'b0;
        end else if (cpu_ce) begin
            put <= ~put;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (cpu_ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_nxt = put ? READ : ALIGN;
`else
                state_nxt = READ;
`endif
            end
            ALIGN: state_nxt = READ;
            READ:  state_nxt = WRITE;
            WRITE: state_nxt = (idx == 8'hFF) ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            page   <= 8'h00;
            idx    <= 8'h00;
            data_q <= 8'h00;
        end else if (cpu_ce) begin
            if (state == IDLE && trigger) begin
                page <= cpu_wdata;
                idx  <= 8'h00;
            end
            if (state == READ) begin
                data_q <= bus_rdata;
            end
            if (state == WRITE) begin
                idx <= idx + 8'h01;
            end
        end
    end

    // Outputs decode the registered state; only IDLE is a combinational bypass.
    always_comb begin
        rdy        = 1'b0;
        dma_active = 1'b1;
        bus_cs     = 1'b1;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        bus_addr   = 16'h0000;
        bus_wdata  = data_q;
        unique case (state)
            IDLE: begin
                rdy        = 1'b1;
                dma_active = 1'b0;
                bus_cs     = cpu_cs;
                bus_rd     = cpu_rd;
                bus_wr     = cpu_wr;
                bus_addr   = cpu_addr;
                bus_wdata  = cpu_wdata;
            end
            READ: begin
                bus_cs   = 1'b0;
                bus_rd   = 1'b1;
                bus_addr = {page, idx};
            end
            WRITE: begin
                bus_cs   = 1'b0;
                bus_wr   = 1'b1;
                bus_addr = OAM_DATA_REG;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: vector table, DMA sequences, random gaps.
// Expected stall honours OAM_DMA_ALIGN_EN the same way the design build does.
module tb_oam_dma_controller;
    import NesBus::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_ce = 1'b0;
    logic        cpu_cs = 1'b1;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        rdy;
    logic        bus_cs;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        dma_active;

    logic [7:0]  mem [65536];
    int          checks = 0;
    int          errors = 0;
    int          ce_count = 0;
    int          stall = 0;
    int          illegal = 0;
    int          bad_par = 0;
    logic [7:0]  wq [$];
    logic [15:0] rq [$];
    logic [7:0]  exp_page;
    int          exp_stall;

    typedef struct {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        exp_rdy;
    } vec_t;

    vec_t vt [6];

    always #5 clk = ~clk;

    oam_dma_controller #(.READ_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_ce    (cpu_ce),
        .cpu_cs    (cpu_cs),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .rdy       (rdy),
        .bus_cs    (bus_cs),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .dma_active(dma_active)
    );

    // Synchronous memory, one clock of read latency.
    always @(posedge clk) begin
        if (!bus_cs && bus_rd) bus_rdata <= mem[bus_addr];
    end

    // Bus observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            ce_count = 0;
        end else begin
            if (dma_active && !bus_cs && bus_wr && bus_addr != OAM_DATA_REG) illegal++;
            if (cpu_ce) begin
                if (!rdy) stall++;
                if (dma_active && !bus_cs && bus_wr) wq.push_back(bus_wdata);
                if (dma_active && !bus_cs && bus_rd) begin
                    rq.push_back(bus_addr);
                    if (ce_count[0]) bad_par++;
                end
                ce_count++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cpu_cycle(
        input int gap, input logic cs, input logic rd, input logic wr,
        input logic [15:0] a, input logic [7:0] d,
        output logic s_cs, output logic s_wr, output logic [15:0] s_addr,
        output logic s_rdy
    );
        cpu_ce = 1'b0;
        cpu_cs = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk);
            #1;
        end
        cpu_ce = 1'b1;
        cpu_cs = cs;
        cpu_rd = rd;
        cpu_wr = wr;
        cpu_addr = a;
        cpu_wdata = d;
        @(negedge clk);
        s_cs = bus_cs;
        s_wr = bus_wr;
        s_addr = bus_addr;
        s_rdy = rdy;
        @(posedge clk);
        #1;
        cpu_ce = 1'b0;
        cpu_cs = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic idle_cycle(input int gap);
        logic c, w, r;
        logic [15:0] a;
        cpu_cycle(gap, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, c, w, a, r);
    endtask

    // Expectation from the parity of the cycle carrying the trigger write.
    task automatic prep_dma(input logic [7:0] page);
        exp_page = page;
        exp_stall = 513;
`ifdef OAM_DMA_ALIGN_EN
        if (ce_count[0]) exp_stall = 514;
`endif
        stall = 0;
        illegal = 0;
        bad_par = 0;
        wq.delete();
        rq.delete();
    endtask

    task automatic finish_dma(input string tag, input bit rand_gap, input bit junk);
        int n;
        int g;
        int bad_d;
        int bad_a;
        logic c, w, r;
        logic [15:0] a;
        check({tag, " rdy_fall"}, int'(rdy), 0);
        n = 0;
        while (!rdy && n < 2000) begin
            g = rand_gap ? int'($urandom_range(2, 7)) : 2;
            if (junk) begin
                cpu_cycle(g, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? OAM_DMA_REG : 16'($urandom),
                          8'($urandom), c, w, a, r);
            end else begin
                idle_cycle(g);
            end
            n++;
        end
        check({tag, " finished"}, int'(n < 2000), 1);
        check({tag, " stall"}, stall, exp_stall);
        check({tag, " wcount"}, wq.size(), 256);
        bad_d = 0;
        bad_a = 0;
        for (int i = 0; i < 256; i++) begin
            if (i >= wq.size() || wq[i] !== mem[{exp_page, 8'(i)}]) bad_d++;
            if (i >= rq.size() || rq[i] !== {exp_page, 8'(i)}) bad_a++;
        end
        check({tag, " data_errs"}, bad_d, 0);
        check({tag, " raddr_errs"}, bad_a, 0);
        check({tag, " stray_wr"}, illegal, 0);
`ifdef OAM_DMA_ALIGN_EN
        check({tag, " read_on_put"}, bad_par, 0);
`endif
        check({tag, " active_end"}, int'(dma_active), 0);
    endtask

    task automatic dma(input logic [7:0] page, input bit want_put,
                       input bit rand_gap, input bit junk, input string tag);
        logic c, w, r;
        logic [15:0] a;
        if (ce_count[0] != want_put) idle_cycle(2);
        prep_dma(page);
        cpu_cycle(2, 1'b0, 1'b0, 1'b1, OAM_DMA_REG, page, c, w, a, r);
        finish_dma(tag, rand_gap, junk);
    endtask

    initial begin
        logic c, w, r;
        logic [15:0] a;
        int n;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        vt[0] = '{1'b0, 1'b0, 1'b1, 16'h4015, 8'h02, 1'b1};
        vt[1] = '{1'b0, 1'b0, 1'b1, 16'h2004, 8'h33, 1'b1};
        vt[2] = '{1'b1, 1'b0, 1'b1, 16'h4014, 8'h02, 1'b1};
        vt[3] = '{1'b0, 1'b1, 1'b0, 16'h4014, 8'h02, 1'b1};
        vt[4] = '{1'b0, 1'b0, 1'b1, 16'h4013, 8'h02, 1'b1};
        vt[5] = '{1'b0, 1'b0, 1'b1, 16'h4014, 8'h02, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset rdy", int'(rdy), 1);
        check("reset dma_active", int'(dma_active), 0);
        cpu_cs = 1'b0;
        cpu_rd = 1'b1;
        cpu_addr = 16'h1234;
        #1;
        check("reset pass addr", int'(bus_addr), 16'h1234);
        check("reset pass rd", int'(bus_rd), 1);
        cpu_cs = 1'b1;
        cpu_rd = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (!vt[i].exp_rdy) prep_dma(vt[i].data);
            cpu_cycle(2, vt[i].cs, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, c, w, a, r);
            check($sformatf("vec%0d pass addr", i), int'(a), int'(vt[i].addr));
            check($sformatf("vec%0d pass cs", i), int'(c), int'(vt[i].cs));
            check($sformatf("vec%0d pass wr", i), int'(w), int'(vt[i].wr));
            check($sformatf("vec%0d rdy during", i), int'(r), 1);
            check($sformatf("vec%0d rdy after", i), int'(rdy), int'(vt[i].exp_rdy));
            if (!vt[i].exp_rdy) finish_dma("vec dma", 1'b0, 1'b0);
        end

        dma(8'h02, 1'b0, 1'b0, 1'b0, "get p02");
        dma(8'h02, 1'b1, 1'b0, 1'b0, "put p02");
        dma(8'h80, 1'b0, 1'b0, 1'b1, "rom p80");

        prep_dma(8'h03);
        cpu_cycle(2, 1'b0, 1'b0, 1'b1, OAM_DMA_REG, 8'h03, c, w, a, r);
        n = 0;
        while (wq.size() < 100 && n < 2000) begin
            idle_cycle(2);
            n++;
        end
        check("rst mid reached", wq.size(), 100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst mid rdy", int'(rdy), 1);
        check("rst mid active", int'(dma_active), 0);
        rst_n = 1'b1;
        repeat (20) idle_cycle(2);
        check("rst mid wcount", wq.size(), 100);
        check("rst mid rdy hold", int'(rdy), 1);
        dma(8'h02, 1'b0, 1'b0, 1'b0, "restart p02");

        dma(8'h02, 1'b0, 1'b1, 1'b0, "gaps get");
        dma(8'h02, 1'b1, 1'b1, 1'b0, "gaps put");
        for (int k = 0; k < 4; k++) begin
            dma(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b1, $sformatf("rand%0d", k));
        end

        cpu_cycle(3, 1'b0, 1'b0, 1'b1, 16'h4015, 8'hFF, c, w, a, r);
        check("post 4015 addr", int'(a), 16'h4015);
        check("post 4015 rdy", int'(rdy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
